posit_operand_decode: RTL and testbench

- Pipelined operand front-end for the posit add/sub datapath.
- Accepts a raw posit pair (a, b) and an op_sub flag. When op_sub=1, b is negated by exact posit two's complement.
- Decodes both operands into sign / scale / mantissa / special flags, which the posit adder core consumes directly.
- 2-stage pipeline with valid/ready handshake and full backpressure; one transaction per cycle at steady state.

---
 rtl/posit_operand_decode_pkg.sv | 31 +++
 rtl/posit_field_extract.sv | 57 +++++
 rtl/two_comp.sv | 11 +
 rtl/posit_operand_decode.sv | 107 ++++++++++
 tb/tb_posit_operand_decode.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/posit_operand_decode_pkg.sv
// Shared types and constants for the posit operand front-end.
// The decoded operand layout is the one the posit adder core consumes.
package posit_operand_decode_pkg;

  localparam int unsigned POSIT_WIDTH   = 32;
  localparam int unsigned POSIT_EN      = 3;
  localparam int unsigned POSIT_SCALE_W = $clog2(POSIT_WIDTH) + POSIT_EN + 2;
  localparam int unsigned POSIT_MANT_W  = POSIT_WIDTH - POSIT_EN - 2;

  typedef struct packed {
    logic                            sign;
    logic                            is_zero;
    logic                            is_nar;
    logic signed [POSIT_SCALE_W-1:0] scale;
    logic [POSIT_MANT_W-1:0]         mant;
  } posit_dec_t;

  // Stage-1 payload: magnitude body (sign bit stripped) plus special flags.
  typedef struct packed {
    logic                    sign;
    logic                    is_zero;
    logic                    is_nar;
    logic [POSIT_WIDTH-2:0]  body;
  } posit_s1_t;

  // NaR pattern for a w-bit posit: MSB set, all other bits clear.
  function automatic logic [POSIT_WIDTH-1:0] posit_nar(input int unsigned w);
    return POSIT_WIDTH'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/posit_field_extract.sv
// Combinational regime/exponent/fraction extraction from a positive posit body.
module posit_field_extract
  import posit_operand_decode_pkg::*;
#(
  parameter int unsigned WIDTH = POSIT_WIDTH,
  parameter int unsigned EN    = POSIT_EN
) (
  input  logic [WIDTH-2:0] body,
  input  logic             sign,
  input  logic             is_zero,
  input  logic             is_nar,
  output posit_dec_t       dec
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned KW    = POSIT_SCALE_W - EN;
  localparam int unsigned LW    = WIDTH - 3;

  logic               r0;
  logic               run_done;
  logic [CNT_W-1:0]   run;
  logic signed [KW-1:0] k;
  logic [LW-1:0]      rem;
  logic [EN-1:0]      e;

  // Leading run length of bits equal to the body MSB.
  always_comb begin
    r0       = body[WIDTH-2];
    run      = '0;
    run_done = 1'b0;
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      if (!run_done && (body[i] == r0)) begin
        run = run + CNT_W'(1);
      end else begin
        run_done = 1'b1;
      end
    end
  end

  // The top two body bits always belong to the run or its terminator, so the
  // low LW bits shifted by (run-1) start exactly at the first exponent bit.
  always_comb begin
    k   = r0 ? (KW'(run) - KW'(1)) : -KW'(run);
    rem = body[LW-1:0] << (run - CNT_W'(1));
    e   = rem[LW-1 -: EN];
    dec = '0;
    if (is_zero || is_nar) begin
      dec.is_zero = is_zero;
      dec.is_nar  = is_nar;
    end else begin
      dec.sign  = sign;
      dec.scale = {k, e};
      dec.mant  = {1'b1, rem[LW-EN-1:0]};
    end
  end

endmodule

// File: rtl/two_comp.sv
// Two's complement negation modulo 2^W.
module two_comp #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = ~x + W'(1);

endmodule

// File: rtl/posit_operand_decode.sv
// Two-stage operand front-end for the posit add/sub datapath: optional b
// negation and sign/special split, then field decode, with full backpressure.
module posit_operand_decode
  import posit_operand_decode_pkg::*;
#(
  parameter int unsigned WIDTH = POSIT_WIDTH,
  parameter int unsigned EN    = POSIT_EN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output posit_dec_t       a_dec,
  output posit_dec_t       b_dec
);

  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s1_move, s2_move;
  posit_s1_t        s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  posit_dec_t       a_dec_q, a_dec_d, b_dec_q, b_dec_d;
  posit_dec_t       a_ext, b_ext;
  logic [WIDTH-1:0] b_neg, b_eff;
  logic [WIDTH-2:0] a_abs, b_abs;
  logic [WIDTH-1:0] nar_pat;

  assign nar_pat = WIDTH'(posit_nar(WIDTH));

  two_comp #(.W(WIDTH)) u_neg_b (.x(b), .y(b_neg));

  assign b_eff = op_sub ? b_neg : b;

  // Low bits of a two's complement depend only on low bits, so abs runs on the body.
  two_comp #(.W(WIDTH-1)) u_abs_a (.x(a[WIDTH-2:0]),     .y(a_abs));
  two_comp #(.W(WIDTH-1)) u_abs_b (.x(b_eff[WIDTH-2:0]), .y(b_abs));

  posit_field_extract #(.WIDTH(WIDTH), .EN(EN)) u_ext_a (
    .body    (s1_a_q.body),
    .sign    (s1_a_q.sign),
    .is_zero (s1_a_q.is_zero),
    .is_nar  (s1_a_q.is_nar),
    .dec     (a_ext)
  );

  posit_field_extract #(.WIDTH(WIDTH), .EN(EN)) u_ext_b (
    .body    (s1_b_q.body),
    .sign    (s1_b_q.sign),
    .is_zero (s1_b_q.is_zero),
    .is_nar  (s1_b_q.is_nar),
    .dec     (b_ext)
  );

  // Handshake chain and next-state for both stages.
  always_comb begin
    s2_move    = !s2_valid_q || out_ready;
    s1_move    = !s1_valid_q || s2_move;
    s1_valid_d = s1_move ? in_valid : s1_valid_q;
    s2_valid_d = s2_move ? s1_valid_q : s2_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    a_dec_d    = a_dec_q;
    b_dec_d    = b_dec_q;
    if (s1_move && in_valid) begin
      s1_a_d.sign    = a[WIDTH-1];
      s1_a_d.is_zero = (a == '0);
      s1_a_d.is_nar  = (a == nar_pat);
      s1_a_d.body    = a[WIDTH-1] ? a_abs : a[WIDTH-2:0];
      s1_b_d.sign    = b_eff[WIDTH-1];
      s1_b_d.is_zero = (b_eff == '0);
      s1_b_d.is_nar  = (b_eff == nar_pat);
      s1_b_d.body    = b_eff[WIDTH-1] ? b_abs : b_eff[WIDTH-2:0];
    end
    if (s2_move && s1_valid_q) begin
      a_dec_d = a_ext;
      b_dec_d = b_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      a_dec_q    <= '0;
      b_dec_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      a_dec_q    <= a_dec_d;
      b_dec_q    <= b_dec_d;
    end
  end

  assign in_ready  = s1_move;
  assign out_valid = s2_valid_q;
  assign a_dec     = a_dec_q;
  assign b_dec     = b_dec_q;

endmodule

// File: tb/tb_posit_operand_decode.sv
// Directed, table-driven bench for posit_operand_decode with backpressure
// and mid-stream reset sequences.
module tb_posit_operand_decode;
  import posit_operand_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  posit_dec_t  a_dec;
  posit_dec_t  b_dec;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op_sub;
    posit_dec_t  ea;
    posit_dec_t  eb;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  posit_operand_decode dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_dec     (a_dec),
    .b_dec     (b_dec)
  );

  function automatic posit_dec_t mk(input logic s, input logic z, input logic n,
                                    input int sc, input logic [26:0] m);
    posit_dec_t d;
    d.sign    = s;
    d.is_zero = z;
    d.is_nar  = n;
    d.scale   = 10'(sc);
    d.mant    = m;
    return d;
  endfunction

  function automatic vec_t mkv(input logic [31:0] va, input logic [31:0] vb,
                               input logic vs, input posit_dec_t ea, input posit_dec_t eb);
    vec_t v;
    v.a = va; v.b = vb; v.op_sub = vs; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v, input logic vld);
    a        = v.a;
    b        = v.b;
    op_sub   = v.op_sub;
    in_valid = vld;
  endtask

  // Single transaction: accept edge, one empty cycle, then the result.
  task automatic send_check(input vec_t v, input int idx);
    out_ready = 1'b1;
    set_in(v, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d_lat1_valid", idx), 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk($sformatf("v%0d_lat2_valid", idx), 64'(out_valid), 64'(1));
    chk($sformatf("v%0d_a_dec", idx), 64'(a_dec), 64'(v.ea));
    chk($sformatf("v%0d_b_dec", idx), 64'(b_dec), 64'(v.eb));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op_sub    = 1'b0;

    vecs[0] = mkv(32'h40000000, 32'h44000000, 1'b0,
                  mk(0,0,0,0,27'h4000000),    mk(0,0,0,1,27'h4000000));
    vecs[1] = mkv(32'h42000000, 32'h40000000, 1'b1,
                  mk(0,0,0,0,27'h6000000),    mk(1,0,0,0,27'h4000000));
    vecs[2] = mkv(32'h00000001, 32'h7FFFFFFF, 1'b0,
                  mk(0,0,0,-240,27'h4000000), mk(0,0,0,240,27'h4000000));
    vecs[3] = mkv(32'h00000000, 32'h80000000, 1'b1,
                  mk(0,1,0,0,27'h0),          mk(0,0,1,0,27'h0));
    vecs[4] = mkv(32'h38000000, 32'h80000000, 1'b0,
                  mk(0,0,0,-2,27'h4000000),   mk(0,0,1,0,27'h0));
    vecs[5] = mkv(32'hC0000000, 32'hBC000000, 1'b1,
                  mk(1,0,0,0,27'h4000000),    mk(0,0,0,1,27'h4000000));
    vecs[6] = mkv(32'h7FFFFFFF, 32'h00000001, 1'b1,
                  mk(0,0,0,240,27'h4000000),  mk(1,0,0,-240,27'h4000000));
    vecs[7] = mkv(32'h40000001, 32'h60000000, 1'b0,
                  mk(0,0,0,0,27'h4000001),    mk(0,0,0,8,27'h4000000));
    vecs[8] = mkv(32'h7FFFFFFE, 32'h00000003, 1'b0,
                  mk(0,0,0,232,27'h4000000),  mk(0,0,0,-228,27'h4000000));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_a_dec", 64'(a_dec), 64'(0));
    chk("rst_b_dec", 64'(b_dec), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < NV; i++) send_check(vecs[i], i);

    // Drain, then backpressure with three pairs
    @(posedge clk); #1;
    chk("drain_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b0;
    set_in(vecs[0], 1'b1);
    chk("bp_rdy0", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    set_in(vecs[1], 1'b1);
    chk("bp_rdy1", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    set_in(vecs[2], 1'b1);
    chk("bp_rdy_full", 64'(in_ready), 64'(0));
    chk("bp_valid", 64'(out_valid), 64'(1));
    chk("bp_a0", 64'(a_dec), 64'(vecs[0].ea));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_rdy", c), 64'(in_ready), 64'(0));
      chk($sformatf("bp_hold%0d_valid", c), 64'(out_valid), 64'(1));
      chk($sformatf("bp_hold%0d_a", c), 64'(a_dec), 64'(vecs[0].ea));
      chk($sformatf("bp_hold%0d_b", c), 64'(b_dec), 64'(vecs[0].eb));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_out1_valid", 64'(out_valid), 64'(1));
    chk("bp_out1_a", 64'(a_dec), 64'(vecs[1].ea));
    chk("bp_out1_b", 64'(b_dec), 64'(vecs[1].eb));
    @(posedge clk); #1;
    chk("bp_out2_valid", 64'(out_valid), 64'(1));
    chk("bp_out2_a", 64'(a_dec), 64'(vecs[2].ea));
    chk("bp_out2_b", 64'(b_dec), 64'(vecs[2].eb));
    @(posedge clk); #1;
    chk("bp_empty_valid", 64'(out_valid), 64'(0));

    // Mid-stream asynchronous reset with two pairs in flight
    out_ready = 1'b0;
    set_in(vecs[3], 1'b1);
    @(posedge clk); #1;
    set_in(vecs[4], 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mr_pre_valid", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("mr_valid", 64'(out_valid), 64'(0));
    chk("mr_a_dec", 64'(a_dec), 64'(0));
    chk("mr_b_dec", 64'(b_dec), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mr_in_ready", 64'(in_ready), 64'(1));
    chk("mr_post_valid", 64'(out_valid), 64'(0));
    send_check(vecs[5], 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
